jstk_spi_responder: RTL and testbench
=====================================

// Module: jstk_spi_responder
// PURPOSE
//  SPI-mode-0 slave that emulates the PmodJSTK joystick: answers the 5-byte frame issued by the
//  joystick SPI master with X/Y position and button bytes, and decodes the LED command in byte 0.
//  Sits on the Clk_100MHz domain; drives a loopback paddle source for bench/board-to-board play.
// PARAMETERS
//  SYNC_STAGES  2   flops per SCLK/SS/MOSI synchronizer (>=2)
//  NUM_BYTES    5   bytes per frame carrying data; later bytes return 8'h00
//  DATA_W       10  width of X/Y position inputs
// PORTS
//  Clk_100MHz  in   1       system clock, all logic rising-edge
//  Reset_n     in   1       asynchronous, active-low reset
//  SCLK        in   1       SPI clock from master (async)
//  SS          in   1       SPI select, active-low (async)
//  MOSI        in   1       master data (async)
//  MISO        out  1       slave data, MSB first
//  MISO_oe     out  1       1 while frame active; pad driver enable
//  PosX/PosY   in   DATA_W  joystick position to report
//  Buttons     in   3       {trigger, btn2, btn1}
//  Led         out  2       LED bits from last valid command
//  FrameDone   out  1       1-cycle pulse: frame ended with >=NUM_BYTES whole bytes
//  FrameErr    out  1       1-cycle pulse: SS rose mid-byte or before NUM_BYTES bytes
//  FrameCount  out  16      completed-frame counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, snapshot regs 0. Inputs pass SYNC_STAGES sync + edge detect.
//  Timing: SCLK high/low >=4 Clk_100MHz periods (<=12.5 MHz); MISO updates <=SYNC_STAGES+2 cycles
//  after a synchronized SCLK fall.
//  FSM IDLE -> SHIFT on SS fall: snapshot PosX/PosY/Buttons (frame coherent), byte_cnt=0, bit_cnt=0,
//    load tx=byte0, MISO=tx[7], MISO_oe=1.
//  SHIFT: SCLK rise -> rx={rx[6:0],MOSI}, bit_cnt++; SCLK fall with bit_cnt!=0 -> shift tx, MISO=next bit.
//    bit_cnt==8 at SCLK rise: byte complete, byte_cnt++ (saturates at 7); next tx byte loaded for
//    following SCLK fall. byte_cnt reaching NUM_BYTES -> TRAIL.
//  TRAIL: further bytes shifted out as 8'h00; rx ignored.
//  Any state: SS rise -> IDLE, MISO=0, MISO_oe=0 same cycle as edge detect. FrameDone if
//    byte_cnt>=NUM_BYTES and bit_cnt==0, else FrameErr (partial byte discarded). Never both.
//  Byte map: b0=X[7:0], b1={6'b0,X[9:8]}, b2=Y[7:0], b3={6'b0,Y[9:8]}, b4={5'b0,Buttons}.
//    DATA_W<10: zero-extend; DATA_W>10 unsupported (elaboration error).
//  LED: on completion of byte 0, if rx[7:2]==6'b100000 then Led<=rx[1:0], else Led unchanged.
//  SCLK edges while SS high ignored. SS fall and SCLK edge in same cycle: SS handled first,
//    the SCLK edge is ignored.
//  Reset_n low mid-frame: immediate return to reset values; next SS fall starts fresh frame.
// CONFIGURATION
//  JSTK_RSP_FRAMECNT_EN defined: FrameCount increments on every FrameDone, wraps 16'hFFFF->0.
//  Undefined: FrameCount tied to 16'h0000, counter logic absent; all other behaviour identical.
// STRUCTURE
//  Package jstk_pkg: JSTK_NUM_BYTES=5, JSTK_LED_PREFIX=6'b100000, state enum {IDLE,SHIFT,TRAIL},
//    byte-index constants.
//  Sub-module spi_in_sync: SYNC_STAGES synchronizer + rise/fall detect, instanced for SCLK,SS,MOSI.
// TESTING
//  1 PosX=10'h2A5,PosY=10'h13C,Buttons=3'b101, 5-byte frame, MOSI=8'h83 then 0s ->
//    MISO A5,02,3C,01,05; Led=2'b11; one FrameDone; FrameCount=1 (macro on).
//  2 Byte0 MOSI=8'h40 -> Led holds 2'b11; data bytes correct; FrameDone.
//  3 SS rises after 13 SCLKs -> FrameErr once, no FrameDone, MISO_oe=0, next frame correct.
//  4 7-byte frame -> bytes 5,6 read 8'h00; FrameDone once.
//  5 PosX changed 8'hFF mid-frame -> frame still reports snapshot 10'h2A5.
//  6 Reset_n low during byte 2 -> Led=0, MISO_oe=0, FrameCount=0; next frame clean.

Source files
------------

// File: rtl/jstk_spi_responder_pkg.sv
// Shared constants, state encoding and byte-map helper for the PmodJSTK SPI responder.
package jstk_pkg;

    localparam int         JSTK_NUM_BYTES  = 5;
    localparam logic [5:0] JSTK_LED_PREFIX = 6'b100000;

    localparam logic [2:0] JSTK_B_XLO = 3'd0;
    localparam logic [2:0] JSTK_B_XHI = 3'd1;
    localparam logic [2:0] JSTK_B_YLO = 3'd2;
    localparam logic [2:0] JSTK_B_YHI = 3'd3;
    localparam logic [2:0] JSTK_B_BTN = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRAIL = 2'd2
    } jstk_state_e;

    // Byte returned to the master at position idx of a frame.
    function automatic logic [7:0] jstk_frame_byte(
        input logic [2:0] idx,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        logic [7:0] b;
        case (idx)
            JSTK_B_XLO: b = x[7:0];
            JSTK_B_XHI: b = {6'b000000, x[9:8]};
            JSTK_B_YLO: b = y[7:0];
            JSTK_B_YHI: b = {6'b000000, y[9:8]};
            JSTK_B_BTN: b = {5'b00000, btn};
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between the joystick master and the responder.
interface jstk_spi_if;
    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;
    logic MISO_oe;

    modport master (output SCLK, output SS, output MOSI, input MISO, input MISO_oe);
    modport slave  (input SCLK, input SS, input MOSI, output MISO, output MISO_oe);
endinterface

// File: rtl/jstk_spi_responder_sync.sv
// spi_in_sync: multi-flop synchronizer with registered-history rise/fall detection.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the async input through the chain and keep one cycle of history.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK-emulating SPI mode-0 slave. Optional frame counter enabled by JSTK_RSP_FRAMECNT_EN.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = JSTK_NUM_BYTES,
    parameter int DATA_W      = 10
) (
    input  logic              Clk_100MHz,
    input  logic              Reset_n,
    jstk_spi_if.slave         spi,
    input  logic [DATA_W-1:0] PosX,
    input  logic [DATA_W-1:0] PosY,
    input  logic [2:0]        Buttons,
    output logic [1:0]        Led,
    output logic              FrameDone,
    output logic              FrameErr,
    output logic [15:0]       FrameCount
);

    if (DATA_W < 1 || DATA_W > 10) begin : g_bad_data_w
        $error("jstk_spi_responder: DATA_W must be in 1..10");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 7) begin : g_bad_num_bytes
        $error("jstk_spi_responder: NUM_BYTES must be in 1..7");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("jstk_spi_responder: SYNC_STAGES must be >= 2");
    end

    localparam logic [2:0] NB_L = 3'(NUM_BYTES);

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic ss_lvl_s, ss_rise_s, ss_fall_s;
    logic mosi_s, mosi_rise_s, mosi_fall_s;
    logic sync_unused_s;

    // SS idles high, so its synchronizer resets high to avoid a false edge.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(Clk_100MHz), .rst_n(Reset_n), .d(spi.SCLK),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(Clk_100MHz), .rst_n(Reset_n), .d(spi.SS),
        .level(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_s));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(Clk_100MHz), .rst_n(Reset_n), .d(spi.MOSI),
        .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s));

    assign sync_unused_s = ^{sclk_lvl_s, ss_lvl_s, mosi_rise_s, mosi_fall_s};

    jstk_state_e state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [2:0]  btn_q, btn_d;
    logic [1:0]  led_q, led_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [9:0]  x_ext_s, y_ext_s;
    logic [2:0]  next_cnt_s;
    logic [7:0]  rx_shift_s;
    logic [7:0]  next_tx_s;

    assign x_ext_s = 10'(PosX);
    assign y_ext_s = 10'(PosY);

    // Frame FSM: SS edges take priority over any SCLK edge seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        led_d      = led_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        next_cnt_s = (byte_cnt_q == 3'd7) ? 3'd7 : byte_cnt_q + 3'd1;
        rx_shift_s = {rx_q[6:0], mosi_s};
        next_tx_s  = (next_cnt_s < NB_L) ? jstk_frame_byte(next_cnt_s, x_q, y_q, btn_q) : 8'h00;

        case (state_q)
            IDLE: begin
                if (ss_fall_s) begin
                    x_d        = x_ext_s;
                    y_d        = y_ext_s;
                    btn_d      = Buttons;
                    byte_cnt_d = 3'd0;
                    bit_cnt_d  = 3'd0;
                    rx_d       = 8'h00;
                    tx_d       = jstk_frame_byte(JSTK_B_XLO, x_ext_s, y_ext_s, Buttons);
                    miso_d     = tx_d[7];
                    oe_d       = 1'b1;
                    state_d    = SHIFT;
                end else begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                end
            end
            SHIFT, TRAIL: begin
                if (ss_rise_s) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                    if (byte_cnt_q >= NB_L && bit_cnt_q == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    if (state_q == SHIFT) begin
                        rx_d = rx_shift_s;
                    end else begin
                        rx_d = rx_q;
                    end
                    // Eighth rising edge closes the byte; its successor is staged for the next fall.
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = next_cnt_s;
                        tx_d       = next_tx_s;
                        if (state_q == SHIFT && byte_cnt_q == JSTK_B_XLO &&
                            rx_shift_s[7:2] == JSTK_LED_PREFIX) begin
                            led_d = rx_shift_s[1:0];
                        end else begin
                            led_d = led_q;
                        end
                        if (next_cnt_s >= NB_L) begin
                            state_d = TRAIL;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        miso_d = tx_q[6];
                    end else begin
                        miso_d = tx_q[7];
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Frame state, snapshot and output registers.
    always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            x_q        <= 10'h000;
            y_q        <= 10'h000;
            btn_q      <= 3'b000;
            led_q      <= 2'b00;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            led_q      <= led_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef JSTK_RSP_FRAMECNT_EN
    logic [15:0] fcnt_q, fcnt_d;

    // Completed-frame counter, wrapping naturally at 16 bits.
    always_comb begin
        if (done_d) begin
            fcnt_d = fcnt_q + 16'd1;
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            fcnt_q <= 16'h0000;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign FrameCount = fcnt_q;
`else
    assign FrameCount = 16'h0000;
`endif

    assign spi.MISO    = miso_q;
    assign spi.MISO_oe = oe_q;
    assign Led         = led_q;
    assign FrameDone   = done_q;
    assign FrameErr    = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: drives SPI frames as the joystick master.
module tb_jstk_spi_responder;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [2:0]  btn;
    logic [1:0]  led;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_count;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   exp_frames = 0;
    int   d0 = 0;
    int   e0 = 0;
    logic cnt_en;
    logic [7:0] got;

    logic [7:0] exp_bytes [0:4] = '{8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05};

    jstk_spi_if spi_if ();

    jstk_spi_responder dut (
        .Clk_100MHz (clk),
        .Reset_n    (rst_n),
        .spi        (spi_if),
        .PosX       (pos_x),
        .PosY       (pos_y),
        .Buttons    (btn),
        .Led        (led),
        .FrameDone  (frame_done),
        .FrameErr   (frame_err),
        .FrameCount (frame_count)
    );

    always #5 clk = ~clk;

    // Count one-cycle status pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
    end

    task check(input string tag, input logic [15:0] got_v, input logic [15:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_if.MOSI = mo[i];
            #HALF;
            mi = {mi[6:0], spi_if.MISO};
            spi_if.SCLK = 1'b1;
            #HALF;
            spi_if.SCLK = 1'b0;
        end
    endtask

    task begin_frame;
        d0 = done_cnt;
        e0 = err_cnt;
        spi_if.SS = 1'b0;
        #HALF;
        check("oe_active", 16'(spi_if.MISO_oe), 16'h0001);
    endtask

    task end_frame(input int exp_done, input int exp_err);
        #HALF;
        spi_if.SS = 1'b1;
        #200;
        check("done_pulses", 16'(done_cnt - d0), 16'(exp_done));
        check("err_pulses", 16'(err_cnt - e0), 16'(exp_err));
        check("oe_idle", 16'(spi_if.MISO_oe), 16'h0000);
        check("miso_idle", 16'(spi_if.MISO), 16'h0000);
        check("frame_count", frame_count, cnt_en ? 16'(exp_frames) : 16'h0000);
    endtask

    task run_bytes(input int n, input logic [7:0] mo0);
        logic [7:0] rd;
        logic [7:0] exp_b;
        for (int i = 0; i < n; i++) begin
            xfer((i == 0) ? mo0 : 8'h00, 8, rd);
            exp_b = (i < 5) ? exp_bytes[i] : 8'h00;
            check("miso_byte", 16'(rd), 16'(exp_b));
        end
    endtask

    initial begin
`ifdef JSTK_RSP_FRAMECNT_EN
        cnt_en = 1'b1;
`else
        cnt_en = 1'b0;
`endif
        rst_n       = 1'b0;
        spi_if.SS   = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        pos_x       = 10'h2A5;
        pos_y       = 10'h13C;
        btn         = 3'b101;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_led", 16'(led), 16'h0000);
        check("rst_oe", 16'(spi_if.MISO_oe), 16'h0000);
        check("rst_miso", 16'(spi_if.MISO), 16'h0000);
        check("rst_done", 16'(frame_done), 16'h0000);
        check("rst_err", 16'(frame_err), 16'h0000);
        check("rst_count", frame_count, 16'h0000);

        // Basic frame with a valid LED command 0x83.
        begin_frame();
        run_bytes(5, 8'h83);
        exp_frames++;
        end_frame(1, 0);
        check("t1_led", 16'(led), 16'h0003);

        // Non-command byte 0 leaves the LEDs alone.
        begin_frame();
        run_bytes(5, 8'h40);
        exp_frames++;
        end_frame(1, 0);
        check("t2_led", 16'(led), 16'h0003);

        // SS rises after 13 SCLKs: error, then a clean frame.
        begin_frame();
        xfer(8'h00, 8, got);
        check("t3_b0", 16'(got), 16'h00A5);
        xfer(8'h00, 5, got);
        check("t3_partial", 16'(got), 16'h0000);
        end_frame(0, 1);
        begin_frame();
        run_bytes(5, 8'h00);
        exp_frames++;
        end_frame(1, 0);

        // Seven-byte frame: trailing bytes read zero.
        begin_frame();
        run_bytes(7, 8'h00);
        exp_frames++;
        end_frame(1, 0);

        // Position changes mid-frame do not reach the current frame.
        begin_frame();
        pos_x = 10'h0FF;
        run_bytes(5, 8'h00);
        exp_frames++;
        end_frame(1, 0);
        pos_x = 10'h2A5;

        // Reset asserted during byte 2.
        begin_frame();
        xfer(8'h83, 8, got);
        check("t6_b0", 16'(got), 16'h00A5);
        xfer(8'h00, 8, got);
        check("t6_b1", 16'(got), 16'h0002);
        xfer(8'h00, 4, got);
        rst_n = 1'b0;
        #30;
        check("t6_led", 16'(led), 16'h0000);
        check("t6_oe", 16'(spi_if.MISO_oe), 16'h0000);
        check("t6_miso", 16'(spi_if.MISO), 16'h0000);
        check("t6_count", frame_count, 16'h0000);
        spi_if.SS = 1'b1;
        #30;
        rst_n = 1'b1;
        exp_frames = 0;
        #200;
        check("t6_no_pulse", 16'((done_cnt - d0) + (err_cnt - e0)), 16'h0000);
        begin_frame();
        run_bytes(5, 8'h00);
        exp_frames++;
        end_frame(1, 0);
        check("t6_led_after", 16'(led), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
